dtm_dmi_ctrl: RTL
=================

DTM_DMI_CTRL -- requirements
Module: dtm_dmi_ctrl

Interface
REQ-001 Parameter IDCODE_VAL, default 32'h1000_0DB3, value returned for the IDCODE register.
REQ-002 Parameter IDLE_HINT, default 3'd1, value reported in dtmcs.idle.
REQ-003 Clocking: one clock; reset is asynchronous and active-low; ports named tclk and trst_n.
REQ-004 Ports, one per line (name, direction, width, meaning):
- tclk  in  1  JTAG clock.
- trst_n  in  1  async active-low reset.
- wr_en  in  1  one-cycle DR-update pulse from the TAP.
- wr_data  in  DMI_WIDTH  updated DR value.
- wr_rdy  out  1  write-accept to the TAP.
- rd_addr  in  IR_REG_WIRTH  current IR selection.
- rd_data  out  DMI_WIDTH  capture value for the selected DR.
- dmi_req_vld  out  1  DM request valid.
- dmi_req_rdy  in  1  DM request ready.
- dmi_req_addr  out  DMI_ADDR  DM register address.
- dmi_req_data  out  32  write data.
- dmi_req_op  out  2  1=read, 2=write.
- dmi_rsp_vld  in  1  DM response valid.
- dmi_rsp_rdy  out  1  DM response ready.
- dmi_rsp_data  in  32  response data.
- dmi_rsp_op  in  2  0=ok, 2=failed, 3=busy.

Function
REQ-005 Field layout of a DMI write: addr=wr_data[DMI_WIDTH-1:34], data=wr_data[33:2], op=wr_data[1:0].
REQ-006 rd_data is combinational on rd_addr:
- IDCODE: zero-extended IDCODE_VAL.
- DTMCS: zero-extended dtmcs.
- DMI: {last_addr, rsp_data_q, status}.
- BYPASS or any other address: 0.
REQ-007 dtmcs layout: [3:0]=1, [9:4]=DMI_ADDR, [11:10]=dmistat (sticky), [14:12]=IDLE_HINT, all other bits 0.
REQ-008 DMI status field is 3 while the FSM is not IDLE, otherwise it is the sticky value.
REQ-009 wr_rdy is registered: 0 in reset, 1 from the first clock after reset onwards.
REQ-010 FSM states and transitions:
- IDLE -> REQ on a DMI write with op 1 or 2 while sticky==0.
- REQ -> RSP on dmi_req_vld&&dmi_req_rdy.
- RSP -> IDLE on dmi_rsp_vld&&dmi_rsp_rdy.
REQ-011 Request latency and hold: wr_en at cycle T asserts dmi_req_vld at T+1; addr, data and op are registered and held stable until the handshake completes.
REQ-012 DMI writes with op 0 or op 3 issue no request; last_addr is still updated to the written address.
REQ-013 A DMI write while the FSM is not IDLE is dropped and sets sticky to 3 if sticky is 0.
REQ-014 A DMI write while sticky is nonzero is ignored (no request, no state change).
REQ-015 On response handshake: rsp_data_q <= dmi_rsp_data; sticky <= dmi_rsp_op when sticky==0 and dmi_rsp_op!=0.
REQ-016 dmi_rsp_rdy is 1 in RSP and in IDLE, 0 in REQ; a response arriving in IDLE is accepted and discarded.
REQ-017 DTMCS write with bit16 (dmireset) set clears sticky to 0.
REQ-018 DTMCS write with bit17 (dmihardreset) set clears sticky and forces the FSM to IDLE from any state.
REQ-019 Effect of dmihardreset on DM signals: dmi_req_vld drops the next cycle; a late response is discarded per REQ-016.
REQ-020 Writes to IDCODE, BYPASS or unknown addresses have no effect.
REQ-021 Simultaneous response handshake and DMI write in the same cycle: response takes effect first; the write is treated as arriving in the busy state (REQ-013).

Reset
REQ-022 Reset values: FSM=IDLE, sticky=0, last_addr=0, rsp_data_q=0, dmi_req_vld=0, dmi_req_addr/data/op=0, wr_rdy=0.
REQ-023 Assertion of trst_n mid-transaction aborts it; no response is expected afterwards.

Structure
REQ-024 debug_pack holds DMI_WIDTH, DMI_ADDR, IR_REG_WIRTH, the *_REG_ADDR constants, the DMI op/status enum and the FSM state enum.
REQ-025 Single module, no sub-modules; clock-domain crossing toward the DM is out of scope.

Verification
REQ-026 Read: DMI write addr=0x11, op=1; DM returns data 0xDEADBEEF, op 0 -> request at T+1 with op 1; DMI capture = {0x11, 0xDEADBEEF, 0}.
REQ-027 Write-while-busy: second DMI write while dmi_req_rdy is held 0 -> no second request; after the response, dtmcs[11:10]=3 and DMI status=3.
REQ-028 Failed response: DM returns op 2 -> dmistat=2; a subsequent DMI write issues no request; DTMCS write 0x10000 -> dmistat=0; the next write issues a request.
REQ-029 Hard reset: DTMCS write 0x20000 while in RSP -> FSM goes to IDLE; a late dmi_rsp_vld is accepted, rsp_data_q is unchanged.
REQ-030 Capture values: rd_addr=IDCODE -> 0x10000DB3; rd_addr=DTMCS with DMI_ADDR=7 -> 0x1071; BYPASS -> 0.
REQ-031 Async reset: trst_n pulsed low mid-REQ -> dmi_req_vld=0 immediately; wr_rdy=0, then 1 one clock after release.

Source files
------------

// File: rtl/debug_pack.sv
// debug_pack: shared widths, IR register addresses and encodings for the DTM.
package debug_pack;

  localparam int DMI_ADDR     = 7;
  localparam int DMI_WIDTH    = DMI_ADDR + 34;
  localparam int IR_REG_WIRTH = 5;

  localparam logic [IR_REG_WIRTH-1:0] IDCODE_REG_ADDR = 5'h01;
  localparam logic [IR_REG_WIRTH-1:0] DTMCS_REG_ADDR  = 5'h10;
  localparam logic [IR_REG_WIRTH-1:0] DMI_REG_ADDR    = 5'h11;
  localparam logic [IR_REG_WIRTH-1:0] BYPASS_REG_ADDR = 5'h1f;

  typedef enum logic [1:0] {
    DMI_OP_NOP   = 2'd0,
    DMI_OP_READ  = 2'd1,
    DMI_OP_WRITE = 2'd2,
    DMI_OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    DMI_ST_OK     = 2'd0,
    DMI_ST_RSVD   = 2'd1,
    DMI_ST_FAILED = 2'd2,
    DMI_ST_BUSY   = 2'd3
  } dmi_status_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_REQ  = 2'd1,
    FSM_RSP  = 2'd2
  } dmi_fsm_e;

  // Builds the dtmcs capture word: version 1, abits, dmistat and idle hint.
  function automatic logic [31:0] makeDtmcs(input logic [1:0] dmiStat,
                                            input logic [2:0] idleHint);
    makeDtmcs = {17'd0, idleHint, dmiStat, 6'(DMI_ADDR), 4'd1};
  endfunction

endpackage

// File: rtl/dtm_dmi_ctrl.sv
// dtm_dmi_ctrl: turns TAP DR updates into DMI requests toward the debug
// module, tracks the sticky DMI error and provides the DR capture values.
module dtm_dmi_ctrl
  import debug_pack::*;
#(
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0DB3,
  parameter logic [2:0]  IDLE_HINT  = 3'd1
) (
  input  logic                    tclk,
  input  logic                    trst_n,
  input  logic                    wr_en,
  input  logic [DMI_WIDTH-1:0]    wr_data,
  output logic                    wr_rdy,
  input  logic [IR_REG_WIRTH-1:0] rd_addr,
  output logic [DMI_WIDTH-1:0]    rd_data,
  output logic                    dmi_req_vld,
  input  logic                    dmi_req_rdy,
  output logic [DMI_ADDR-1:0]     dmi_req_addr,
  output logic [31:0]             dmi_req_data,
  output logic [1:0]              dmi_req_op,
  input  logic                    dmi_rsp_vld,
  output logic                    dmi_rsp_rdy,
  input  logic [31:0]             dmi_rsp_data,
  input  logic [1:0]              dmi_rsp_op
);

  dmi_fsm_e            r_state;
  logic [1:0]          r_sticky;
  logic [DMI_ADDR-1:0] r_lastAddr;
  logic [31:0]         r_rspData;
  logic                r_reqVld;
  logic [DMI_ADDR-1:0] r_reqAddr;
  logic [31:0]         r_reqData;
  logic [1:0]          r_reqOp;
  logic                r_wrRdy;

  logic                w_dmiWr;
  logic                w_dtmcsWr;
  logic                w_hardReset;
  logic                w_dmiReset;
  logic [DMI_ADDR-1:0] w_wrAddr;
  logic [31:0]         w_wrData;
  logic [1:0]          w_wrOp;
  logic                w_reqHs;
  logic                w_rspHs;
  logic                w_rspRdy;
  logic [1:0]          w_dmiStatus;

  assign w_dmiWr     = wr_en && (rd_addr == DMI_REG_ADDR);
  assign w_dtmcsWr   = wr_en && (rd_addr == DTMCS_REG_ADDR);
  assign w_hardReset = w_dtmcsWr && wr_data[17];
  assign w_dmiReset  = w_dtmcsWr && wr_data[16];
  assign w_wrAddr    = wr_data[DMI_WIDTH-1:34];
  assign w_wrData    = wr_data[33:2];
  assign w_wrOp      = wr_data[1:0];
  assign w_reqHs     = r_reqVld && dmi_req_rdy;
  assign w_rspRdy    = (r_state != FSM_REQ);
  assign w_rspHs     = dmi_rsp_vld && w_rspRdy;
  assign w_dmiStatus = (r_state != FSM_IDLE) ? DMI_ST_BUSY : r_sticky;

  assign wr_rdy       = r_wrRdy;
  assign dmi_req_vld  = r_reqVld;
  assign dmi_req_addr = r_reqAddr;
  assign dmi_req_data = r_reqData;
  assign dmi_req_op   = r_reqOp;
  assign dmi_rsp_rdy  = w_rspRdy;

  // The TAP may write from the first clock after reset is released.
  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      r_wrRdy <= 1'b0;
    end else begin
      r_wrRdy <= 1'b1;
    end
  end

  // DMI transaction FSM; a response in the same cycle as a write is applied first, so the write sees a busy controller.
  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      r_state    <= FSM_IDLE;
      r_sticky   <= DMI_ST_OK;
      r_lastAddr <= '0;
      r_rspData  <= '0;
      r_reqVld   <= 1'b0;
      r_reqAddr  <= '0;
      r_reqData  <= '0;
      r_reqOp    <= '0;
    end else if (w_hardReset) begin
      r_state  <= FSM_IDLE;
      r_sticky <= DMI_ST_OK;
      r_reqVld <= 1'b0;
    end else begin
      case (r_state)
        FSM_IDLE: begin
          if (w_dmiWr && (r_sticky == DMI_ST_OK)) begin
            r_lastAddr <= w_wrAddr;
            if ((w_wrOp == DMI_OP_READ) || (w_wrOp == DMI_OP_WRITE)) begin
              r_state   <= FSM_REQ;
              r_reqVld  <= 1'b1;
              r_reqAddr <= w_wrAddr;
              r_reqData <= w_wrData;
              r_reqOp   <= w_wrOp;
            end
          end
        end
        FSM_REQ: begin
          if (w_reqHs) begin
            r_state  <= FSM_RSP;
            r_reqVld <= 1'b0;
          end
          if (w_dmiWr && (r_sticky == DMI_ST_OK)) begin
            r_sticky <= DMI_ST_BUSY;
          end
        end
        FSM_RSP: begin
          if (w_rspHs) begin
            r_state   <= FSM_IDLE;
            r_rspData <= dmi_rsp_data;
            if ((r_sticky == DMI_ST_OK) && (dmi_rsp_op != DMI_ST_OK)) begin
              r_sticky <= dmi_rsp_op;
            end else if (w_dmiWr && (r_sticky == DMI_ST_OK)) begin
              r_sticky <= DMI_ST_BUSY;
            end
          end else if (w_dmiWr && (r_sticky == DMI_ST_OK)) begin
            r_sticky <= DMI_ST_BUSY;
          end
        end
        default: begin
          r_state  <= FSM_IDLE;
          r_reqVld <= 1'b0;
        end
      endcase
      if (w_dmiReset) begin
        r_sticky <= DMI_ST_OK;
      end
    end
  end

  // Capture value of the DR currently selected by the IR.
  always_comb begin
    rd_data = '0;
    case (rd_addr)
      IDCODE_REG_ADDR: rd_data = DMI_WIDTH'(IDCODE_VAL);
      DTMCS_REG_ADDR:  rd_data = DMI_WIDTH'(makeDtmcs(r_sticky, IDLE_HINT));
      DMI_REG_ADDR:    rd_data = {r_lastAddr, r_rspData, w_dmiStatus};
      BYPASS_REG_ADDR: rd_data = '0;
      default:         rd_data = '0;
    endcase
  end

endmodule
